mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side end of the CPU load/store handshake. Samples rwToMem/addrToMem/dataToMem,
//  waits a parameterised latency, then performs the read or write. Raises a one-cycle
//  rdEn/wtEn (with dataFromMem on reads).
//  Sits between processor and a word-addressed storage array. Stands in for cache+memory in system sims.
// PARAMETERS
//  RD_LAT     2  cycles from request-capture edge to rdEn edge (>=1)
//  WT_LAT     3  cycles from request-capture edge to wtEn edge (>=1)
//  INIT_ZERO  1  1: array zeroed at time 0 (sim only); 0: contents X
// PORTS
//  clk          in   1              single clock, rising edge
//  reset        in   1              asynchronous, active-low
//  rwToMem      in   `IOSTATEWIDTH  request code: `IDEL / `RD / `WT
//  addrToMem    in   `ADDRWIDTH     word address
//  dataToMem    in   `WORDWIDTH     write data
//  rdEn         out  1              read done; one-cycle pulse
//  wtEn         out  1              write done; one-cycle pulse
//  dataFromMem  out  `WORDWIDTH     read data, valid while rdEn=1
//  memState     out  2              debug: current FSM state
//  protErr      out  1              debug: one-cycle pulse on protocol violation
// BEHAVIOUR
//  Reset (reset=0, async): state=M_IDLE, rdEn=0, wtEn=0, dataFromMem=0, protErr=0, counter=0.
//   Array contents are untouched.
//  All outputs registered. Storage depth = 2**`ADDRWIDTH words.
//  FSM states:
//   M_IDLE : rwToMem==`RD or `WT at edge E0 -> latch op/addr/data; counter=LAT-1; go M_BUSY.
//            `IDEL -> stay. Any other code -> stay, protErr=1 for one cycle.
//   M_BUSY : counter!=0 -> counter-1.
//            counter==0 -> perform access at this edge (edge E0+LAT); go M_ACK.
//            On that edge: RD -> dataFromMem=array[addr], rdEn=1.
//                          WT -> array[addr]=data, wtEn=1.
//   M_ACK  : edge after the pulse -> rdEn=wtEn=0.
//            rwToMem==`IDEL -> M_IDLE; else -> M_HOLD.
//   M_HOLD : wait for rwToMem==`IDEL, then -> M_IDLE. Never re-triggers on a stale request.
//  Latency: E0 samples the request; rdEn/wtEn is high for exactly the cycle after edge E0+LAT.
//   The CPU drops to `IDEL on the edge that samples rdEn/wtEn=1, so M_ACK normally returns to M_IDLE.
//   Minimum occupancy is LAT+1 cycles per transaction.
//  Operand handling: request is latched at E0. Changes to rwToMem/addr/data during M_BUSY are ignored.
//   A non-`IDEL code that differs from the latched op during M_BUSY pulses protErr;
//   the transaction completes with the latched values.
//  dataFromMem holds its last read value after rdEn falls. It is unchanged by writes.
//  Read-after-write to the same address returns the new data: the write commits before the next E0.
//  counter width = clog2(max(RD_LAT,WT_LAT))+1. No wrap: it loads only in M_IDLE.
//  Reset mid-transaction: the pending write is dropped (array unchanged), the pending read is dropped,
//   and no rdEn/wtEn is issued. After reset release the FSM is in M_IDLE and a held
//   `RD/`WT is treated as a new request.
// STRUCTURE
//  Shared def.v gains: `MEMSTATEWIDTH (2), `M_IDLE=0, `M_BUSY=1, `M_ACK=2, `M_HOLD=3.
//   It reuses `IDEL/`RD/`WT, `ADDRWIDTH and `WORDWIDTH.
//  One sub-module: mem_array.
//   Ports: clk, we, addr, wdata, rdata. Synchronous write, combinational read.
//   Parameters: width/depth and INIT_ZERO.
//  FSM, counter and output registers stay in mem_responder.
// TESTING
//  1 Write then read: WT addr=5 data=8'hA5 held until wtEn -> wtEn high exactly WT_LAT cycles after
//    capture, for 1 cycle. Then RD addr=5 -> rdEn after RD_LAT cycles, dataFromMem=8'hA5.
//  2 Processor-accurate loop: connect processor running SET r0,0x3C; ST r0,9; LD r1,9.
//    Expect r1==0x3C, pc==3, and no protErr.
//  3 Sticky request: hold RD addr=2 for 10 cycles after rdEn -> exactly one rdEn pulse,
//    memState stays M_HOLD until `IDEL, then M_IDLE.
//  4 Mid-flight change: WT addr=1 data=0x11, switch to RD addr=7 during M_BUSY ->
//    protErr pulses, array[1]==0x11, wtEn (not rdEn) pulses, array[7] unchanged.
//  5 Reset mid-write: WT addr=4 data=0xFF, pulse reset=0 one cycle before wtEn ->
//    no wtEn, array[4] keeps its old value, all outputs 0.
//  6 Illegal code 2'b11 in M_IDLE -> protErr one cycle, state stays M_IDLE, no access performed.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: request codes, bus widths
// and the responder FSM state encoding.
package mem_responder_pkg;

    localparam int IOSTATEWIDTH  = 2;
    localparam int ADDRWIDTH     = 4;
    localparam int WORDWIDTH     = 8;
    localparam int MEMSTATEWIDTH = 2;

    // Request codes driven by the CPU on rwToMem; 2'b11 is illegal
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

    typedef enum logic [MEMSTATEWIDTH-1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_ACK  = 2'd2,
        M_HOLD = 2'd3
    } mem_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, combinational read.
// Contents are never touched by reset.
module mem_array #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int INIT_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    // Power-up contents for simulation: all zero, or unknown when INIT_ZERO=0
    logic [WIDTH-1:0] mem [DEPTH] = '{default: ((INIT_ZERO != 0) ? {WIDTH{1'b0}} : {WIDTH{1'bx}})};

    // Commit a write on the clock edge selected by the responder
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the CPU load/store handshake. Captures a request,
// waits RD_LAT/WT_LAT cycles, performs the access and raises a one-cycle
// rdEn/wtEn. A request still held after the ack is parked in M_HOLD so it
// cannot re-trigger.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int RD_LAT    = 2,
    parameter int WT_LAT    = 3,
    parameter int INIT_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IOSTATEWIDTH-1:0]  rwToMem,
    input  logic [ADDRWIDTH-1:0]     addrToMem,
    input  logic [WORDWIDTH-1:0]     dataToMem,
    output logic                     rdEn,
    output logic                     wtEn,
    output logic [WORDWIDTH-1:0]     dataFromMem,
    output logic [MEMSTATEWIDTH-1:0] memState,
    output logic                     protErr
);

    localparam int CW = $clog2(max_int(RD_LAT, WT_LAT)) + 1;

    mem_state_t              state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [IOSTATEWIDTH-1:0] op_q;
    logic [ADDRWIDTH-1:0]    addr_q;
    logic [WORDWIDTH-1:0]    data_q;
    logic                    capture;
    logic                    rden_d, wten_d, perr_d;
    logic [WORDWIDTH-1:0]    dout_d;
    logic                    we;
    logic [WORDWIDTH-1:0]    rdata;

    mem_array #(
        .WIDTH     (WORDWIDTH),
        .DEPTH     (2 ** ADDRWIDTH),
        .INIT_ZERO (INIT_ZERO)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (rdata)
    );

    // Next-state, counter and next-output decode
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        rden_d  = 1'b0;
        wten_d  = 1'b0;
        perr_d  = 1'b0;
        dout_d  = dataFromMem;
        we      = 1'b0;
        case (state)
            M_IDLE: begin
                if (rwToMem == RD) begin
                    capture = 1'b1;
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = M_BUSY;
                end else if (rwToMem == WT) begin
                    capture = 1'b1;
                    cnt_d   = CW'(WT_LAT - 1);
                    state_d = M_BUSY;
                end else if (rwToMem != IDEL) begin
                    perr_d = 1'b1;
                end
            end
            M_BUSY: begin
                // The latched request wins; a conflicting live code is only flagged
                if (rwToMem != IDEL && rwToMem != op_q) begin
                    perr_d = 1'b1;
                end
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    state_d = M_ACK;
                    if (op_q == RD) begin
                        rden_d = 1'b1;
                        dout_d = rdata;
                    end else begin
                        wten_d = 1'b1;
                        we     = 1'b1;
                    end
                end
            end
            M_ACK: begin
                state_d = (rwToMem == IDEL) ? M_IDLE : M_HOLD;
            end
            M_HOLD: begin
                if (rwToMem == IDEL) begin
                    state_d = M_IDLE;
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    // State, counter and registered outputs; reset drops any pending access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= M_IDLE;
            cnt         <= '0;
            rdEn        <= 1'b0;
            wtEn        <= 1'b0;
            dataFromMem <= '0;
            protErr     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            rdEn        <= rden_d;
            wtEn        <= wten_d;
            dataFromMem <= dout_d;
            protErr     <= perr_d;
        end
    end

    // Request operands are frozen at the capture edge
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q   <= rwToMem;
            addr_q <= addrToMem;
            data_q <= dataToMem;
        end
    end

    assign memState = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (RD_LAT=2, WT_LAT=3).
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rwToMem;
    logic [3:0] addrToMem;
    logic [7:0] dataToMem;
    logic       rdEn, wtEn, protErr;
    logic [7:0] dataFromMem;
    logic [1:0] memState;

    int checks = 0;
    int passed = 0;
    logic perr_seen = 1'b0;

    mem_responder #(.RD_LAT(2), .WT_LAT(3), .INIT_ZERO(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .rwToMem     (rwToMem),
        .addrToMem   (addrToMem),
        .dataToMem   (dataToMem),
        .rdEn        (rdEn),
        .wtEn        (wtEn),
        .dataFromMem (dataFromMem),
        .memState    (memState),
        .protErr     (protErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (protErr) perr_seen = 1'b1;
    endtask

    // Issue a request and wait (bounded) for its completion pulse
    task automatic do_req(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                          input int lat, input string tag);
        int n;
        rwToMem = op; addrToMem = a; dataToMem = d;
        tick();
        n = 0;
        while (!(rdEn || wtEn) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_rdEn"}, rdEn, (op == RD));
        check({tag, "_wtEn"}, wtEn, (op == WT));
    endtask

    // CPU drops the request on the edge that sees the pulse
    task automatic finish_req(input string tag);
        rwToMem = IDEL;
        tick();
        check({tag, "_pulse_end"}, rdEn | wtEn, 1'b0);
        check({tag, "_idle"}, memState, M_IDLE);
    endtask

    initial begin
        int pulses;
        reset = 1'b0; rwToMem = IDEL; addrToMem = '0; dataToMem = '0;
        tick(); tick();
        check("rst_state", memState, M_IDLE);
        check("rst_en", {rdEn, wtEn}, 2'b00);
        check("rst_dout", dataFromMem, 8'h00);
        check("rst_perr", protErr, 1'b0);
        reset = 1'b1;
        tick();

        // Write then read back
        do_req(WT, 4'd5, 8'hA5, 3, "t1_wr");
        finish_req("t1_wr");
        do_req(RD, 4'd5, 8'h00, 2, "t1_rd");
        check("t1_rd_data", dataFromMem, 8'hA5);
        finish_req("t1_rd");
        check("t1_dout_hold", dataFromMem, 8'hA5);

        // Store/load pair as a CPU would issue it
        perr_seen = 1'b0;
        do_req(WT, 4'd9, 8'h3C, 3, "t2_st");
        finish_req("t2_st");
        do_req(RD, 4'd9, 8'h00, 2, "t2_ld");
        check("t2_ld_data", dataFromMem, 8'h3C);
        finish_req("t2_ld");
        check("t2_no_perr", perr_seen, 1'b0);

        // Sticky request parks in M_HOLD
        do_req(WT, 4'd2, 8'h5A, 3, "t3_wr");
        finish_req("t3_wr");
        do_req(RD, 4'd2, 8'h00, 2, "t3_rd");
        check("t3_data", dataFromMem, 8'h5A);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rdEn) pulses++;
        end
        check("t3_extra_pulses", pulses, 0);
        check("t3_hold", memState, M_HOLD);
        rwToMem = IDEL;
        tick();
        check("t3_release", memState, M_IDLE);

        // Mid-flight change is flagged but the latched write completes
        do_req(WT, 4'd7, 8'h77, 3, "t4_pre");
        finish_req("t4_pre");
        rwToMem = WT; addrToMem = 4'd1; dataToMem = 8'h11;
        tick();
        check("t4_busy", memState, M_BUSY);
        rwToMem = RD; addrToMem = 4'd7; dataToMem = 8'h00;
        tick();
        check("t4_perr", protErr, 1'b1);
        rwToMem = IDEL;
        tick();
        check("t4_perr_pulse", protErr, 1'b0);
        tick();
        check("t4_wtEn", wtEn, 1'b1);
        check("t4_no_rdEn", rdEn, 1'b0);
        check("t4_dout_unchanged", dataFromMem, 8'h5A);
        tick();
        check("t4_idle", memState, M_IDLE);
        do_req(RD, 4'd1, 8'h00, 2, "t4_rd1");
        check("t4_arr1", dataFromMem, 8'h11);
        finish_req("t4_rd1");
        do_req(RD, 4'd7, 8'h00, 2, "t4_rd7");
        check("t4_arr7", dataFromMem, 8'h77);
        finish_req("t4_rd7");

        // Reset one cycle before wtEn drops the write
        do_req(WT, 4'd4, 8'h44, 3, "t5_pre");
        finish_req("t5_pre");
        rwToMem = WT; addrToMem = 4'd4; dataToMem = 8'hFF;
        tick(); tick(); tick();
        check("t5_busy", memState, M_BUSY);
        reset = 1'b0; rwToMem = IDEL;
        #1;
        check("t5_async_state", memState, M_IDLE);
        check("t5_async_dout", dataFromMem, 8'h00);
        tick();
        check("t5_no_wtEn", wtEn, 1'b0);
        reset = 1'b1;
        tick();
        check("t5_after_en", {rdEn, wtEn, protErr}, 3'b000);
        check("t5_after_state", memState, M_IDLE);
        do_req(RD, 4'd4, 8'h00, 2, "t5_rd");
        check("t5_arr4_kept", dataFromMem, 8'h44);
        finish_req("t5_rd");

        // Illegal request code in M_IDLE
        rwToMem = 2'b11;
        tick();
        check("t6_perr", protErr, 1'b1);
        check("t6_state", memState, M_IDLE);
        check("t6_no_access", {rdEn, wtEn}, 2'b00);
        rwToMem = IDEL;
        tick();
        check("t6_perr_pulse", protErr, 1'b0);
        check("t6_state2", memState, M_IDLE);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
